// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one byte-addressed data memory port between the CPU
// load/store unit and a debug/loader master. The CPU has priority, but after
// MAX_HOLD consecutive CPU grants with DBG waiting, DBG wins one cycle.
// Each granted read is tagged with its owner, and the read data is returned
// to that owner only, one cycle after the grant.
// Optional feature macro: DMEM_ARB_PERF_EN adds saturating performance
// counters perf_cpu_stall and perf_dbg_grant.
module dmem_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_HOLD = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic [3:0]        cpu_be,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    input  logic [3:0]        dbg_be,
    output logic              dbg_gnt,
    output logic              dbg_rvalid,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [3:0]        mem_be,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef DMEM_ARB_PERF_EN
    ,
    output logic [15:0]       perf_cpu_stall,
    output logic [15:0]       perf_dbg_grant
`endif
);

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_DBG = 1'b1
    } owner_e;

    localparam logic [3:0] MAX_HOLD_C = 4'(MAX_HOLD);

    logic [3:0]  hold_cnt_r;
    logic [3:0]  hold_cnt_nxt_s;
    logic        rd_pend_r;
    owner_e      rd_owner_r;
    logic        cpu_gnt_s;
    logic        dbg_gnt_s;
    logic        rd_grant_s;

    // Arbitration: CPU priority unless DBG has waited through MAX_HOLD CPU grants;
    // grants are suppressed entirely while reset is asserted.
    always_comb begin
        cpu_gnt_s = 1'b0;
        dbg_gnt_s = 1'b0;
        if (rst_n == 1'b0) begin
            cpu_gnt_s = 1'b0;
            dbg_gnt_s = 1'b0;
        end else begin
            case ({cpu_req, dbg_req})
                2'b10: cpu_gnt_s = 1'b1;
                2'b01: dbg_gnt_s = 1'b1;
                2'b11: begin
                    if (hold_cnt_r >= MAX_HOLD_C) begin
                        dbg_gnt_s = 1'b1;
                    end else begin
                        cpu_gnt_s = 1'b1;
                    end
                end
                default: begin
                    cpu_gnt_s = 1'b0;
                    dbg_gnt_s = 1'b0;
                end
            endcase
        end
    end

    assign cpu_gnt = cpu_gnt_s;
    assign dbg_gnt = dbg_gnt_s;
    assign mem_en  = cpu_gnt_s | dbg_gnt_s;

    // Memory-side mux: route the winner's command, drive zeros when idle.
    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_be    = 4'b0000;
        case ({cpu_gnt_s, dbg_gnt_s})
            2'b10: begin
                mem_we    = cpu_we;
                mem_addr  = cpu_addr;
                mem_wdata = cpu_wdata;
                mem_be    = cpu_be;
            end
            2'b01: begin
                mem_we    = dbg_we;
                mem_addr  = dbg_addr;
                mem_wdata = dbg_wdata;
                mem_be    = dbg_be;
            end
            default: begin
                mem_we    = 1'b0;
                mem_addr  = '0;
                mem_wdata = '0;
                mem_be    = 4'b0000;
            end
        endcase
    end

    // Starvation counter: count CPU wins while DBG waits, saturate, clear otherwise.
    always_comb begin
        hold_cnt_nxt_s = 4'd0;
        if (cpu_gnt_s && dbg_req) begin
            if (hold_cnt_r >= MAX_HOLD_C) begin
                hold_cnt_nxt_s = MAX_HOLD_C;
            end else begin
                hold_cnt_nxt_s = hold_cnt_r + 4'd1;
            end
        end else begin
            hold_cnt_nxt_s = 4'd0;
        end
    end

    assign rd_grant_s = (cpu_gnt_s | dbg_gnt_s) & ~mem_we;

    // Arbiter state: starvation counter plus the owner of the read in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt_r <= 4'd0;
            rd_pend_r  <= 1'b0;
            rd_owner_r <= OWN_CPU;
        end else begin
            hold_cnt_r <= hold_cnt_nxt_s;
            rd_pend_r  <= rd_grant_s;
            if (rd_grant_s) begin
                rd_owner_r <= dbg_gnt_s ? OWN_DBG : OWN_CPU;
            end else begin
                rd_owner_r <= rd_owner_r;
            end
        end
    end

    // Read return: steer memory data only to the owner; the other side sees zero.
    always_comb begin
        cpu_rvalid = 1'b0;
        dbg_rvalid = 1'b0;
        cpu_rdata  = '0;
        dbg_rdata  = '0;
        if (rd_pend_r) begin
            if (rd_owner_r == OWN_DBG) begin
                dbg_rvalid = 1'b1;
                dbg_rdata  = mem_rdata;
            end else begin
                cpu_rvalid = 1'b1;
                cpu_rdata  = mem_rdata;
            end
        end else begin
            cpu_rvalid = 1'b0;
            dbg_rvalid = 1'b0;
        end
    end

`ifdef DMEM_ARB_PERF_EN
    logic [15:0] perf_cpu_stall_r;
    logic [15:0] perf_dbg_grant_r;

    // Saturating counters for CPU stall cycles and DBG grant cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_cpu_stall_r <= 16'd0;
            perf_dbg_grant_r <= 16'd0;
        end else begin
            if (cpu_req && !cpu_gnt_s && (perf_cpu_stall_r != 16'hFFFF)) begin
                perf_cpu_stall_r <= perf_cpu_stall_r + 16'd1;
            end else begin
                perf_cpu_stall_r <= perf_cpu_stall_r;
            end
            if (dbg_gnt_s && (perf_dbg_grant_r != 16'hFFFF)) begin
                perf_dbg_grant_r <= perf_dbg_grant_r + 16'd1;
            end else begin
                perf_dbg_grant_r <= perf_dbg_grant_r;
            end
        end
    end

    assign perf_cpu_stall = perf_cpu_stall_r;
    assign perf_dbg_grant = perf_dbg_grant_r;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with a small DataMem model.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cpu_req, cpu_we, dbg_req, dbg_we;
    logic [31:0] cpu_addr, cpu_wdata, dbg_addr, dbg_wdata;
    logic [3:0]  cpu_be, dbg_be;
    logic        cpu_gnt, cpu_rvalid, dbg_gnt, dbg_rvalid;
    logic [31:0] cpu_rdata, dbg_rdata;
    logic        mem_en, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;
`ifdef DMEM_ARB_PERF_EN
    logic [15:0] perf_cpu_stall, perf_dbg_grant;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] mem [0:15];

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_HOLD(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_be(cpu_be), .cpu_gnt(cpu_gnt),
        .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
        .dbg_wdata(dbg_wdata), .dbg_be(dbg_be), .dbg_gnt(dbg_gnt),
        .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_rdata(mem_rdata)
`ifdef DMEM_ARB_PERF_EN
        , .perf_cpu_stall(perf_cpu_stall), .perf_dbg_grant(perf_dbg_grant)
`endif
    );

    // DataMem model: byte-enabled writes, registered read data.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                for (int b = 0; b < 4; b++)
                    if (mem_be[b]) mem[mem_addr[5:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
            end else begin
                mem_rdata <= mem[mem_addr[5:2]];
            end
        end
    end

    task automatic idle();
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 32'h0; cpu_wdata = 32'h0; cpu_be = 4'b0000;
        dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = 32'h0; dbg_wdata = 32'h0; dbg_be = 4'b0000;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle();
        cpu_req = 1'b1; dbg_req = 1'b1;
        @(negedge clk); #1;
        n_checks++; if (cpu_gnt !== 1'b0 || dbg_gnt !== 1'b0) $display("FAIL reset_gnt got %b%b exp 00", cpu_gnt, dbg_gnt); else n_pass++;
        n_checks++; if (mem_en !== 1'b0) $display("FAIL reset_mem_en got %b exp 0", mem_en); else n_pass++;
        n_checks++; if (cpu_rvalid !== 1'b0 || dbg_rvalid !== 1'b0) $display("FAIL reset_rvalid got %b%b exp 00", cpu_rvalid, dbg_rvalid); else n_pass++;
        @(negedge clk);
        rst_n = 1'b1; #1;
        n_checks++; if (cpu_gnt !== 1'b1 || dbg_gnt !== 1'b0) $display("FAIL reset_first_gnt got %b%b exp 10", cpu_gnt, dbg_gnt); else n_pass++;
        @(negedge clk); idle(); #1;
        n_checks++; if (mem_en !== 1'b0 || mem_addr !== 32'h0 || mem_we !== 1'b0) $display("FAIL idle_mem got en=%b addr=%h exp 0/0", mem_en, mem_addr); else n_pass++;
    endtask

    task automatic test_cpu_load();
        @(negedge clk);
        idle(); cpu_req = 1'b1; cpu_addr = 32'h4; cpu_be = 4'b1111; #1;
        n_checks++; if (cpu_gnt !== 1'b1 || dbg_gnt !== 1'b0) $display("FAIL load_gnt got %b%b exp 10", cpu_gnt, dbg_gnt); else n_pass++;
        n_checks++; if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h4) $display("FAIL load_mem got en=%b we=%b addr=%h exp 1/0/4", mem_en, mem_we, mem_addr); else n_pass++;
        @(negedge clk); idle(); #1;
        n_checks++; if (cpu_rvalid !== 1'b1 || cpu_rdata !== 32'hDEADBEEF) $display("FAIL load_rdata got %b %h exp 1 deadbeef", cpu_rvalid, cpu_rdata); else n_pass++;
        n_checks++; if (dbg_rvalid !== 1'b0 || dbg_rdata !== 32'h0) $display("FAIL load_dbg_side got %b %h exp 0 0", dbg_rvalid, dbg_rdata); else n_pass++;
    endtask

    task automatic test_dbg_store();
        @(negedge clk);
        idle(); dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 32'h0; dbg_wdata = 32'h00000012; dbg_be = 4'b1111; #1;
        n_checks++; if (dbg_gnt !== 1'b1 || cpu_gnt !== 1'b0) $display("FAIL store_gnt got %b%b exp 01", cpu_gnt, dbg_gnt); else n_pass++;
        n_checks++; if (mem_we !== 1'b1 || mem_wdata !== 32'h12 || mem_be !== 4'b1111 || mem_addr !== 32'h0) $display("FAIL store_mem got we=%b wd=%h be=%b addr=%h exp 1/12/1111/0", mem_we, mem_wdata, mem_be, mem_addr); else n_pass++;
        @(negedge clk); idle(); #1;
        n_checks++; if (dbg_rvalid !== 1'b0 || cpu_rvalid !== 1'b0) $display("FAIL store_no_rvalid got %b%b exp 00", cpu_rvalid, dbg_rvalid); else n_pass++;
        n_checks++; if (mem[0] !== 32'h00000012) $display("FAIL store_data got %h exp 00000012", mem[0]); else n_pass++;
    endtask

    task automatic test_contention();
        logic [11:0] exp_cpu;
        exp_cpu = 12'b111101111011;
        @(negedge clk); idle();
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h8; cpu_wdata = 32'h11; cpu_be = 4'b1111;
            dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 32'hC; dbg_wdata = 32'h22; dbg_be = 4'b1111; #1;
            n_checks++; if (cpu_gnt !== exp_cpu[11-i] || dbg_gnt !== ~exp_cpu[11-i]) $display("FAIL contention_c%0d got cpu=%b dbg=%b exp cpu=%b", i, cpu_gnt, dbg_gnt, exp_cpu[11-i]); else n_pass++;
        end
        @(negedge clk); idle();
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        idle(); cpu_req = 1'b1; cpu_addr = 32'h0; cpu_be = 4'b1111; #1;
        n_checks++; if (cpu_gnt !== 1'b1) $display("FAIL b2b_cpu_gnt got %b exp 1", cpu_gnt); else n_pass++;
        @(negedge clk);
        idle(); dbg_req = 1'b1; dbg_addr = 32'h4; dbg_be = 4'b1111; #1;
        n_checks++; if (dbg_gnt !== 1'b1 || mem_addr !== 32'h4) $display("FAIL b2b_dbg_gnt got %b addr=%h exp 1 4", dbg_gnt, mem_addr); else n_pass++;
        n_checks++; if (cpu_rvalid !== 1'b1 || cpu_rdata !== 32'h00000012 || dbg_rvalid !== 1'b0) $display("FAIL b2b_cpu_ret got %b %h dbgv=%b exp 1 00000012 0", cpu_rvalid, cpu_rdata, dbg_rvalid); else n_pass++;
        @(negedge clk); idle(); #1;
        n_checks++; if (dbg_rvalid !== 1'b1 || dbg_rdata !== 32'hDEADBEEF || cpu_rvalid !== 1'b0 || cpu_rdata !== 32'h0) $display("FAIL b2b_dbg_ret got %b %h cpuv=%b exp 1 deadbeef 0", dbg_rvalid, dbg_rdata, cpu_rvalid); else n_pass++;
    endtask

    task automatic test_reset_mid_read();
        logic [4:0] exp_cpu;
        exp_cpu = 5'b11110;
        @(negedge clk); idle();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h4; cpu_be = 4'b1111;
            dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h0; dbg_be = 4'b1111; #1;
            if (i == 3) begin
                n_checks++; if (cpu_gnt !== 1'b1) $display("FAIL midrd_gnt got %b exp 1", cpu_gnt); else n_pass++;
            end
        end
        #2 rst_n = 1'b0; #1;
        n_checks++; if (cpu_gnt !== 1'b0 || dbg_gnt !== 1'b0 || mem_en !== 1'b0) $display("FAIL midrd_forced got %b%b en=%b exp 000", cpu_gnt, dbg_gnt, mem_en); else n_pass++;
        @(negedge clk); #1;
        n_checks++; if (cpu_rvalid !== 1'b0 || dbg_rvalid !== 1'b0) $display("FAIL midrd_rvalid got %b%b exp 00", cpu_rvalid, dbg_rvalid); else n_pass++;
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            cpu_req = 1'b1; dbg_req = 1'b1; cpu_we = 1'b1; dbg_we = 1'b1; #1;
            n_checks++; if (cpu_gnt !== exp_cpu[4-i] || dbg_gnt !== ~exp_cpu[4-i]) $display("FAIL postrst_c%0d got cpu=%b dbg=%b exp cpu=%b", i, cpu_gnt, dbg_gnt, exp_cpu[4-i]); else n_pass++;
        end
        @(negedge clk); idle();
    endtask

`ifdef DMEM_ARB_PERF_EN
    task automatic test_perf();
        @(negedge clk); idle(); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            cpu_req = 1'b1; dbg_req = 1'b1; cpu_we = 1'b1; dbg_we = 1'b1;
            @(negedge clk);
        end
        idle(); #1;
        n_checks++; if (perf_cpu_stall !== 16'd2) $display("FAIL perf_stall got %0d exp 2", perf_cpu_stall); else n_pass++;
        n_checks++; if (perf_dbg_grant !== 16'd2) $display("FAIL perf_dbg got %0d exp 2", perf_dbg_grant); else n_pass++;
        rst_n = 1'b0; #1;
        n_checks++; if (perf_cpu_stall !== 16'd0 || perf_dbg_grant !== 16'd0) $display("FAIL perf_reset got %0d %0d exp 0 0", perf_cpu_stall, perf_dbg_grant); else n_pass++;
        @(negedge clk); rst_n = 1'b1;
    endtask
`endif

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 32'h0;
        mem[0] = 32'hCAFEF00D;
        mem[1] = 32'hDEADBEEF;
        mem_rdata = 32'h0;
        test_reset();
        test_cpu_load();
        test_dbg_store();
        test_contention();
        test_back_to_back();
        test_reset_mid_read();
`ifdef DMEM_ARB_PERF_EN
        test_perf();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
